uart_rx_cfg: RTL
================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 uart_rx. Configurable data width, parity and stop-bit count, with start-bit glitch rejection, parity, framing and break detection. Sits between the pad-side serial input and the byte consumer (command parser / sort FSM front end). Delivers one received word per frame with a one-cycle valid strobe.

Parameters:
CLKS_PER_BIT, 87, clocks per bit period (10 MHz / 115200); legal range is 4 or more (8 or more with UART_RX_MAJORITY_EN)
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first on the line
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits checked, legal 1 or 2

Ports:
i_Clock  in  1  system clock; all logic on rising edge
i_Rst_n  in  1  synchronous active-low reset
i_Rx_Serial  in  1  asynchronous serial line, idle high
o_Rx_DV  out  1  one-cycle strobe: word and error flags valid
o_Rx_Byte  out  DATA_BITS  last received word; holds until the next o_Rx_DV
o_Parity_Err  out  1  parity mismatch for the current word; valid with o_Rx_DV
o_Frame_Err  out  1  a checked stop bit was sampled low; valid with o_Rx_DV
o_Break  out  1  all data bits 0, parity bit (if any) 0 and stop bit 0; valid with o_Rx_DV
o_Rx_Active  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Clock and reset: one clock, i_Clock. Reset is synchronous and active-low on i_Rst_n.
- Reset values:
  - o_Rx_DV, o_Parity_Err, o_Frame_Err, o_Break, o_Rx_Active = 0
  - o_Rx_Byte = 0
  - both synchroniser flops = 1
  - FSM = IDLE; bit counter and clock counter = 0
- Input synchronisation: 2-flop synchroniser on i_Rx_Serial. All decisions use the synchronised value "rx_s".
- Clock counter: width $clog2(CLKS_PER_BIT). Cleared on every state transition.
- FSM states: IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_HIGH.
- IDLE: rx_s == 0 moves to START.
- START: at count == (CLKS_PER_BIT-1)/2, sample rx_s.
  - rx_s == 0: go to DATA. This recentres sampling at mid-bit.
  - rx_s == 1: glitch; return to IDLE with no output activity.
- DATA: at count == CLKS_PER_BIT-1, sample rx_s into shift-register bit [bit_idx], then increment bit_idx.
  - After DATA_BITS samples, go to PARITY if PARITY_MODE != 0, else STOP.
- PARITY: sample at count == CLKS_PER_BIT-1.
  - Error when (XOR of data ^ parity bit) != (PARITY_MODE == 1).
  - Odd mode: total number of ones, including the parity bit, must be odd. Even mode: must be even.
- STOP: sample at count == CLKS_PER_BIT-1, STOP_BITS times.
  - Any low sample sets the framing error.
  - Both stop bits are sampled even if the first one fails.
- CLEANUP: lasts exactly one cycle.
  - Assert o_Rx_DV = 1 and load o_Rx_Byte and the three flags in the same cycle.
  - A word is delivered even when errors are flagged.
  - Next state is WAIT_HIGH if rx_s == 0, else IDLE.
- WAIT_HIGH: stay until rx_s == 1, then go to IDLE. A held-low line (break) never re-arms the receiver.
- Flags: o_Parity_Err, o_Frame_Err and o_Break are pulses aligned with o_Rx_DV and are 0 in all other cycles. o_Break implies o_Frame_Err.
- Latency: o_Rx_DV asserts 1 cycle after the final stop-bit sample, plus the 2-cycle synchroniser delay from the line.
- Back-to-back frames: a start edge arriving on the first IDLE cycle after CLEANUP is accepted. There is no dead time beyond one cycle.
- Reset mid-frame: the partial frame is discarded and no o_Rx_DV is issued. The next complete frame after reset release is received normally.
- Unsupported parameter values are rejected with an elaboration-time $error.

Optional Feature:
Macro: UART_RX_MAJORITY_EN.
- Defined: each sample point uses a 2-of-3 majority of rx_s taken at counts T-2, T-1 and T, where T is the single-sample point above. This applies to the start check and to data, parity and stop samples. It rejects a single-cycle glitch at the sample point. Requires CLKS_PER_BIT >= 8.
- Not defined: single sample at T. The majority logic and its 3-bit history register are absent.

Test Plan:
All scenarios use CLKS_PER_BIT=16 unless stated.
1. 8N1: send 0x3F, then 0xAB back-to-back -> two single-cycle o_Rx_DV pulses with o_Rx_Byte 0x3F then 0xAB; all flags 0.
2. Start glitch: line low for 4 clocks, then high -> no o_Rx_DV; o_Rx_Active returns to 0 within 8 clocks; a following 0x55 frame is received correctly.
3. PARITY_MODE=2: send 0xA5 with parity bit 1 (correct value is 0) -> o_Rx_DV with o_Rx_Byte = 0xA5 and o_Parity_Err = 1. Resend with parity bit 0 -> o_Parity_Err = 0.
4. Framing and break:
   - 0x3C with stop bit 0 -> o_Frame_Err = 1, o_Break = 0.
   - Line held low for 30 bit times -> one o_Rx_DV with o_Rx_Byte = 0x00, o_Frame_Err = 1 and o_Break = 1; no further o_Rx_DV while the line stays low.
   - Line then released and 0x81 sent -> 0x81 received correctly.
5. Reset mid-frame: drive i_Rst_n low for 2 clocks during data bit 3 of 0xAB, then send 0x3F -> exactly one o_Rx_DV, carrying 0x3F; all outputs read 0 during reset.
6. DATA_BITS=7, STOP_BITS=2, PARITY_MODE=1:
   - Send 0x7F -> received correctly, no flags.
   - Second stop bit low -> o_Frame_Err = 1.
   - With UART_RX_MAJORITY_EN defined, inject a 1-cycle inverted glitch at every data sample point of 0x2A -> 0x2A received, no errors.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS/PARITY_MODE/STOP_BITS, glitch-filtered start, parity/frame/break flags.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote at every sample point (needs CLKS_PER_BIT >= 8).
`timescale 1ns/1ps
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Rx_Active
);

`ifdef UART_RX_MAJORITY_EN
    localparam int MIN_CLKS = 8;
`else
    localparam int MIN_CLKS = 4;
`endif
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_PT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             ODD_MODE  = (PARITY_MODE == 1) ? 1'b1 : 1'b0;

    if (CLKS_PER_BIT < MIN_CLKS || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY_MODE < 0 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
        $error("uart_rx_cfg: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_CLEANUP   = 3'd5,
        S_WAIT_HIGH = 3'd6
    } state_t;

    // True when the received word plus parity bit violates the configured parity sense.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        return ((^d) ^ p) != ODD_MODE;
    endfunction

    state_t                 state_r;
    state_t                 next_state_s;
    logic                   rx_meta_r;
    logic                   rx_sync_r;
    logic                   rx_s;
    logic                   sample_s;
    logic [CNT_W-1:0]       clk_cnt_r;
    logic [IDX_W-1:0]       bit_idx_r;
    logic                   stop_idx_r;
    logic [DATA_BITS-1:0]   data_r;
    logic                   par_bit_r;
    logic                   par_err_r;
    logic                   frame_err_r;
    logic                   stop_low_r;
    logic                   bit_tick_s;
    logic                   half_tick_s;
    logic                   done_s;

    // Two-flop synchroniser for the asynchronous line, idle high.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= i_Rx_Serial;
            rx_sync_r <= rx_meta_r;
        end
    end

    assign rx_s = rx_sync_r;

`ifdef UART_RX_MAJORITY_EN
    // Majority of three one-bit samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // hist_r[1] holds rx_s from count T-2, hist_r[0] from T-1; rx_s itself is the T sample.
    logic [1:0] hist_r;

    // Sample history for the majority vote.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            hist_r <= 2'b11;
        end else begin
            hist_r <= {hist_r[0], rx_s};
        end
    end

    assign sample_s = majority3(hist_r[1], hist_r[0], rx_s);
`else
    assign sample_s = rx_s;
`endif

    assign bit_tick_s  = (clk_cnt_r == BIT_LAST);
    assign half_tick_s = (clk_cnt_r == HALF_PT);
    assign done_s      = (state_r == S_STOP) && bit_tick_s && (stop_idx_r == STOP_LAST);

    // Frame-sequencing next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!rx_s) next_state_s = S_START;
                else       next_state_s = S_IDLE;
            end
            S_START: begin
                if (half_tick_s) next_state_s = sample_s ? S_IDLE : S_DATA;
                else             next_state_s = S_START;
            end
            S_DATA: begin
                if (bit_tick_s && (bit_idx_r == IDX_LAST))
                    next_state_s = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                else
                    next_state_s = S_DATA;
            end
            S_PARITY: begin
                if (bit_tick_s) next_state_s = S_STOP;
                else            next_state_s = S_PARITY;
            end
            S_STOP: begin
                if (done_s) next_state_s = S_CLEANUP;
                else        next_state_s = S_STOP;
            end
            S_CLEANUP: begin
                if (!rx_s) next_state_s = S_WAIT_HIGH;
                else       next_state_s = S_IDLE;
            end
            S_WAIT_HIGH: begin
                if (rx_s) next_state_s = S_IDLE;
                else      next_state_s = S_WAIT_HIGH;
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) state_r <= S_IDLE;
        else          state_r <= next_state_s;
    end

    // Bit timing, data capture and per-frame error accumulation.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            clk_cnt_r   <= {CNT_W{1'b0}};
            bit_idx_r   <= {IDX_W{1'b0}};
            stop_idx_r  <= 1'b0;
            data_r      <= {DATA_BITS{1'b0}};
            par_bit_r   <= 1'b0;
            par_err_r   <= 1'b0;
            frame_err_r <= 1'b0;
            stop_low_r  <= 1'b1;
        end else begin
            // Explicit wrap: CLKS_PER_BIT need not be a power of two.
            if ((next_state_s != state_r) || bit_tick_s) clk_cnt_r <= {CNT_W{1'b0}};
            else                                         clk_cnt_r <= clk_cnt_r + CNT_W'(1);
            case (state_r)
                S_START: begin
                    bit_idx_r   <= {IDX_W{1'b0}};
                    stop_idx_r  <= 1'b0;
                    par_bit_r   <= 1'b0;
                    par_err_r   <= 1'b0;
                    frame_err_r <= 1'b0;
                    stop_low_r  <= 1'b1;
                end
                S_DATA: begin
                    if (bit_tick_s) begin
                        data_r[bit_idx_r] <= sample_s;
                        bit_idx_r         <= bit_idx_r + IDX_W'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_tick_s) begin
                        par_bit_r <= sample_s;
                        par_err_r <= parity_bad(data_r, sample_s);
                    end
                end
                S_STOP: begin
                    if (bit_tick_s) begin
                        stop_idx_r  <= stop_idx_r + 1'b1;
                        frame_err_r <= frame_err_r | ~sample_s;
                        stop_low_r  <= stop_low_r & ~sample_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs; the final stop sample folds straight into the flags.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            o_Rx_DV      <= 1'b0;
            o_Rx_Byte    <= {DATA_BITS{1'b0}};
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
            o_Rx_Active  <= 1'b0;
        end else begin
            o_Rx_Active <= (next_state_s != S_IDLE);
            if (done_s) begin
                o_Rx_DV      <= 1'b1;
                o_Rx_Byte    <= data_r;
                o_Parity_Err <= par_err_r;
                o_Frame_Err  <= frame_err_r | ~sample_s;
                o_Break      <= (data_r == {DATA_BITS{1'b0}}) && !par_bit_r && stop_low_r && !sample_s;
            end else begin
                o_Rx_DV      <= 1'b0;
                o_Parity_Err <= 1'b0;
                o_Frame_Err  <= 1'b0;
                o_Break      <= 1'b0;
            end
        end
    end

endmodule
